// File: rtl/des_stream_host.sv
// Host-side packer/collector around the pipelined DES core: pairs 32-bit words into
// blocks, issues them with a held key/mode, and buffers results behind a credit check.
module des_stream_host #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             key_wr,
  input  logic [63:0]      key_data,
  input  logic             key_mode,
  output logic             key_ready,
  output logic             core_valid_in,
  output logic [63:0]      core_plain_text,
  output logic [63:0]      core_cipher_key,
  output logic             core_encrypt_decrypt,
  input  logic             core_valid_out,
  input  logic [63:0]      core_cipher_text,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [CNT_W-1:0] in_flight,
  output logic             err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {EMPTY, HALF} asm_state_e;
  typedef enum logic {HI, LO} phase_e;

  logic             en_q;
  asm_state_e       state_q;
  logic [31:0]      hi_q;
  logic             valid_in_q;
  logic [63:0]      plain_q;
  logic [63:0]      key_q;
  logic             mode_q;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  phase_e           phase_q;

  logic [CNT_W:0]   credit_sum;
  logic             credit_ok, s_hs, m_hs, pop, push, key_load, dec;

  // Every block that could still land in the FIFO is counted, so a result always has a slot.
  assign credit_sum = {1'b0, in_flight_q} + {1'b0, count_q} + (CNT_W+1)'(valid_in_q);
  assign credit_ok  = credit_sum < {1'b0, DEPTH_C};

  assign s_ready   = en_q & ((state_q == EMPTY) | credit_ok);
  assign key_ready = en_q & (in_flight_q == '0) & (state_q == EMPTY) & ~valid_in_q;
  assign s_hs      = s_valid & s_ready;
  assign key_load  = key_wr & key_ready;

  assign m_valid = (count_q != '0);
  assign m_hs    = m_valid & m_ready;
  assign pop     = m_hs & (phase_q == LO);
  assign push    = core_valid_out & (count_q != DEPTH_C);
  assign dec     = core_valid_out & (in_flight_q != '0);

  assign m_data = !m_valid ? '0 :
                  (phase_q == HI) ? mem_q[rd_ptr_q][63:32] : mem_q[rd_ptr_q][31:0];

  assign core_valid_in        = valid_in_q;
  assign core_plain_text      = plain_q;
  assign core_cipher_key      = key_q;
  assign core_encrypt_decrypt = mode_q;
  assign in_flight            = in_flight_q;
  assign err                  = err_q;

  always_comb begin
    in_flight_d = in_flight_q;
    count_d     = count_q;
    case ({valid_in_q, dec})
      2'b10:   in_flight_d = in_flight_q + 1'b1;
      2'b01:   in_flight_d = in_flight_q - 1'b1;
      default: in_flight_d = in_flight_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      hi_q       <= '0;
      valid_in_q <= 1'b0;
      plain_q    <= '0;
    end else begin
      valid_in_q <= 1'b0;
      if (s_hs) begin
        unique case (state_q)
          EMPTY: begin
            hi_q    <= s_data;
            state_q <= HALF;
          end
          HALF: begin
            plain_q    <= {hi_q, s_data};
            valid_in_q <= 1'b1;
            state_q    <= EMPTY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q        <= 1'b0;
      key_q       <= '0;
      mode_q      <= 1'b0;
      in_flight_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      phase_q     <= HI;
    end else begin
      en_q        <= 1'b1;
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      // A result with nothing outstanding means the core and host disagree; latch it.
      err_q       <= err_q | (core_valid_out & (in_flight_q == '0));
      if (key_load) begin
        key_q  <= key_data;
        mode_q <= key_mode;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (m_hs) phase_q  <= (phase_q == HI) ? LO : HI;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= core_cipher_text;
  end

endmodule

// File: tb/tb_des_stream_host.sv
// Randomized scoreboard bench for des_stream_host with a behavioural fixed-latency core stub
// and a block-level model of expected output words, in-flight count and sticky error.
module tb_des_stream_host;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 4;
  localparam int BOUND      = 3000;

  logic             clk, rstn;
  logic             s_valid, s_ready;
  logic [31:0]      s_data;
  logic             key_wr, key_mode, key_ready;
  logic [63:0]      key_data;
  logic             core_valid_in, core_encrypt_decrypt, core_valid_out;
  logic [63:0]      core_plain_text, core_cipher_key, core_cipher_text;
  logic             m_valid, m_ready;
  logic [31:0]      m_data;
  logic [CNT_W-1:0] in_flight;
  logic             err;

  des_stream_host #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .key_wr(key_wr), .key_data(key_data), .key_mode(key_mode), .key_ready(key_ready),
    .core_valid_in(core_valid_in), .core_plain_text(core_plain_text),
    .core_cipher_key(core_cipher_key), .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_valid_out(core_valid_out), .core_cipher_text(core_cipher_text),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .in_flight(in_flight), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; int due; } pipe_t;
  pipe_t       pipe[$];
  logic [31:0] expQ[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, lat = 3, issueCnt = 0, wordsAcc = 0, mMode = 0, infModel = 0;
  logic        errModel = 1'b0, prevVin = 1'b0, injReq = 1'b0, hiPending = 1'b0, tbMode = 1'b0;
  logic [63:0] injData = '0, tbKey = '0;
  logic [31:0] hiWord = '0;

  // Stand-in for the DES core: the published test vector, otherwise a cheap keyed scramble.
  function automatic logic [63:0] coreFn(input logic [63:0] p, input logic [63:0] k, input logic m);
    if (p == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1 && !m)
      return 64'h85E813540F0AB405;
    return {p[62:0], p[63]} ^ k ^ {63'd0, m};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    int t;
    logic [63:0] blk;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
    while (!s_ready && t < BOUND) begin t++; @(negedge clk); end
    if (t >= BOUND) begin
      s_valid = 1'b0;
      checkOutput("s_ready_timeout", 1, 0);
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    wordsAcc++;
    if (!hiPending) begin
      hiWord    = w;
      hiPending = 1'b1;
    end else begin
      blk = coreFn({hiWord, w}, tbKey, tbMode);
      expQ.push_back(blk[63:32]);
      expQ.push_back(blk[31:0]);
      hiPending = 1'b0;
    end
  endtask

  task automatic sendBlock(input int gap);
    applyStimulus($urandom);
    step(gap);
    applyStimulus($urandom);
  endtask

  task automatic loadKey(input logic [63:0] k, input logic m);
    int t;
    t = 0;
    key_wr = 1'b1; key_data = k; key_mode = m;
    @(negedge clk);
    while (!key_ready && t < BOUND) begin t++; @(negedge clk); end
    if (t >= BOUND) begin
      key_wr = 1'b0;
      checkOutput("key_ready_timeout", 1, 0);
      return;
    end
    @(posedge clk); #1;
    key_wr = 1'b0;
    tbKey = k; tbMode = m;
    checkOutput("core_key", core_cipher_key, k);
    checkOutput("core_mode", core_encrypt_decrypt, m);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((expQ.size() != 0 || in_flight != 0 || m_valid || pipe.size() != 0) && t < BOUND) begin
      t++; @(negedge clk);
    end
    checkOutput("drain_timeout", (t >= BOUND), 0);
    step(1);
  endtask

  // Core stub: fixed latency per block, plus an injection path for unsolicited results.
  initial begin
    pipe_t item;
    core_valid_out = 1'b0;
    core_cipher_text = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      core_valid_out = 1'b0;
      if (!rstn) pipe.delete();
      else begin
        if (core_valid_in)
          pipe.push_back('{coreFn(core_plain_text, core_cipher_key, core_encrypt_decrypt), cyc + lat});
        if (injReq) begin
          core_valid_out = 1'b1; core_cipher_text = injData; injReq = 1'b0;
        end else if (pipe.size() != 0 && pipe[0].due <= cyc) begin
          item = pipe.pop_front();
          core_valid_out = 1'b1; core_cipher_text = item.data;
        end
      end
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mMode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard pops on every output handshake; counters follow block-level rules.
  always @(negedge clk) begin
    if (!rstn) begin
      infModel = 0; errModel = 1'b0; prevVin = 1'b0;
    end else begin
      checkOutput("in_flight", in_flight, infModel);
      checkOutput("err", err, errModel);
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL m_data_unexpected: got %h expected none", m_data);
        end else checkOutput("m_data", m_data, expQ.pop_front());
      end
      if (core_valid_in) begin
        issueCnt++;
        checkOutput("vin_one_cycle", prevVin, 0);
      end
      prevVin = core_valid_in;
      if (core_valid_out && infModel == 0) errModel = 1'b1;
      infModel = infModel + int'(core_valid_in) - ((core_valid_out && infModel > 0) ? 1 : 0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; key_wr = 1'b0; key_data = '0; key_mode = 1'b0;
    step(3);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_key_ready", key_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_in_flight", in_flight, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_vin", core_valid_in, 0);
    checkOutput("rst_key", core_cipher_key, 0);
    checkOutput("rst_m_data", m_data, 0);
    rstn = 1'b1;
    checkOutput("s_ready_before_en", s_ready, 0);
    step(1);
    checkOutput("s_ready_after_en", s_ready, 1);
    checkOutput("key_ready_after_en", key_ready, 1);

    $display("[TB] single block");
    loadKey(64'h133457799BBCDFF1, 1'b0);
    mMode = 1;
    applyStimulus(32'h01234567);
    applyStimulus(32'h89ABCDEF);
    checkOutput("issue_pulse", core_valid_in, 1);
    checkOutput("issue_plain", core_plain_text, 64'h0123456789ABCDEF);
    step(1);
    checkOutput("issue_pulse_end", core_valid_in, 0);
    checkOutput("plain_held", core_plain_text, 64'h0123456789ABCDEF);
    drain();
    checkOutput("single_in_flight", in_flight, 0);

    $display("[TB] backpressure");
    mMode = 0; lat = 3; issueCnt = 0; wordsAcc = 0;
    fork
      begin
        for (int b = 0; b < 10; b++) begin applyStimulus($urandom); applyStimulus($urandom); end
      end
      begin
        step(120);
        checkOutput("bp_issues", issueCnt, FIFO_DEPTH);
        checkOutput("bp_words", wordsAcc, 17);
        checkOutput("bp_s_ready", s_ready, 0);
        checkOutput("bp_m_valid", m_valid, 1);
        mMode = 1;
      end
    join
    drain();
    checkOutput("bp_total_issues", issueCnt, 10);

    $display("[TB] key while busy");
    lat = 40; mMode = 1;
    sendBlock(0);
    sendBlock(0);
    step(1);
    checkOutput("busy_in_flight", in_flight, 2);
    checkOutput("busy_key_ready", key_ready, 0);
    key_wr = 1'b1; key_data = 64'hFFFF0000FFFF0000; key_mode = 1'b1;
    step(1);
    key_wr = 1'b0;
    checkOutput("busy_key_kept", core_cipher_key, tbKey);
    checkOutput("busy_mode_kept", core_encrypt_decrypt, tbMode);
    drain();
    loadKey(64'h0E329232EA6D0D73, 1'b1);

    $display("[TB] overlapping issue and return");
    lat = 6; mMode = 1;
    for (int b = 0; b < 8; b++) sendBlock(0);
    drain();

    $display("[TB] random traffic");
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 12); mMode = 2;
      for (int b = 0; b < 8; b++) sendBlock($urandom_range(0, 2));
      drain();
      loadKey({$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset mid-operation");
    mMode = 0; lat = 2;
    sendBlock(0); sendBlock(0);
    step(10);
    lat = 50;
    for (int b = 0; b < 4; b++) sendBlock(0);
    applyStimulus($urandom);
    step(2);
    checkOutput("pre_rst_in_flight", in_flight, 4);
    rstn = 1'b0;
    #1;
    checkOutput("mid_rst_s_ready", s_ready, 0);
    checkOutput("mid_rst_key_ready", key_ready, 0);
    checkOutput("mid_rst_m_valid", m_valid, 0);
    checkOutput("mid_rst_in_flight", in_flight, 0);
    checkOutput("mid_rst_vin", core_valid_in, 0);
    checkOutput("mid_rst_plain", core_plain_text, 0);
    checkOutput("mid_rst_key", core_cipher_key, 0);
    checkOutput("mid_rst_m_data", m_data, 0);
    expQ.delete(); hiPending = 1'b0; tbKey = '0; tbMode = 1'b0;
    step(2);
    rstn = 1'b1; lat = 3;
    checkOutput("rel_s_ready_low", s_ready, 0);
    step(1);
    checkOutput("rel_s_ready", s_ready, 1);
    checkOutput("rel_m_valid", m_valid, 0);

    $display("[TB] unsolicited result");
    mMode = 1;
    injData = 64'hCAFEBABE12345678;
    expQ.push_back(injData[63:32]);
    expQ.push_back(injData[31:0]);
    injReq = 1'b1;
    step(4);
    checkOutput("err_set", err, 1);
    checkOutput("err_in_flight", in_flight, 0);
    drain();
    sendBlock(1); sendBlock(0);
    drain();
    checkOutput("err_sticky", err, 1);
    checkOutput("exp_queue_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_stream_host.md
Name: des_stream_host

Overview:
Host-side driver and collector for the pipelined DES core. It accepts a 32-bit word stream with ready/valid and packs word pairs into 64-bit blocks. Each block is issued to the core as a one-cycle valid pulse with the current key and mode. Core results are captured into a credit-protected FIFO and returned as a 32-bit ready/valid stream, which adds the backpressure the core lacks.

Parameters:
FIFO_DEPTH, 8, result FIFO entries (64-bit); power of 2, at least 2; also the maximum number of blocks in flight plus buffered.
CNT_W, $clog2(FIFO_DEPTH)+1, width of the in-flight and occupancy counters.

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset; shared with the DES core.
s_valid  in  1  input word valid.
s_ready  out  1  input word accepted when s_valid&s_ready.
s_data  in  32  input word; first word of a pair = block[63:32], second = block[31:0].
key_wr  in  1  key/mode load strobe.
key_data  in  64  DES key, parity bits included.
key_mode  in  1  0 = encrypt, 1 = decrypt.
key_ready  out  1  key_wr is honoured this cycle.
core_valid_in  out  1  one-cycle block issue to core.
core_plain_text  out  64  block to core.
core_cipher_key  out  64  held key register.
core_encrypt_decrypt  out  1  held mode register.
core_valid_out  in  1  core result valid.
core_cipher_text  in  64  core result.
m_valid  out  1  output word valid.
m_ready  in  1  output word consumed when m_valid&m_ready.
m_data  out  32  output word; high half first.
in_flight  out  CNT_W  blocks issued but not yet returned.
err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rstn=0): every register and output is 0, including s_ready, key_ready, m_valid, err, counters, key and mode. The FIFO is emptied, the assembly state goes to EMPTY and the output phase goes to HI.
- s_ready and key_ready are gated by an enable flop that sets one cycle after rstn deasserts.
- Assembly FSM has two states, EMPTY and HALF.
  - EMPTY: accepting a word latches it into hi[31:0] and moves to HALF.
  - HALF: accepting a word forms {hi, word}, registers it into core_plain_text, and pulses core_valid_in on the next cycle. The FSM then returns to EMPTY.
- Credit: credit_ok = (in_flight + fifo_count + core_valid_in) < FIFO_DEPTH.
  - s_ready = en & (state==EMPTY | credit_ok).
  - Result: the FIFO can never overflow regardless of core latency.
- core_valid_in is high for exactly one cycle per block. Issue latency is one cycle after the second-word handshake. core_plain_text holds its value until the next issue.
- in_flight: +1 on core_valid_in, -1 on core_valid_out. When both occur in the same cycle, it is unchanged.
- core_valid_out while in_flight==0 sets err (sticky until reset), and in_flight stays 0. The result is still written if the FIFO is not full; otherwise it is dropped.
- FIFO: write on core_valid_out. m_valid = !empty.
  - m_data = entry[63:32] in phase HI and entry[31:0] in phase LO.
  - A handshake in HI moves to LO.
  - A handshake in LO pops the entry and returns to HI.
  - Order is strictly FIFO. A write and a pop in the same cycle are both performed.
- Key/mode: key_ready = en & in_flight==0 & state==EMPTY & !core_valid_in.
  - key_wr with key_ready loads key_data/key_mode into the held registers, visible on core_* the next cycle.
  - key_wr without key_ready is ignored with no side effect. This guarantees mode stays stable for every in-flight block.
- Result FIFO contents may remain buffered during a key change; they belong to the previous key.
- Reset mid-operation: the partial word, in-flight count, FIFO contents and output phase are all discarded. The core shares rstn, so no stale result returns.

Test Plan:
- Single block: load key 0x133457799BBCDFF1, mode 0; send 0x01234567, 0x89ABCDEF -> the cycle after the second handshake, core_valid_in=1 for one cycle with core_plain_text=0x0123456789ABCDEF. When the core model returns 0x85E813540F0AB405 -> m_data 0x85E81354 then 0x0F0AB405; in_flight returns to 0.
- Backpressure, FIFO_DEPTH=8, m_ready=0, 10 blocks offered -> exactly 8 core_valid_in pulses; s_ready low in HALF of block 9. Raise m_ready -> all 10 results emerge in order, each high-then-low, with no loss.
- key_wr with in_flight=2 -> key_ready=0 and core_cipher_key unchanged. After both results return, key_wr with 0x0E329232EA6D0D73, mode 1 -> visible next cycle.
- Issue and result in the same cycle with in_flight=3 -> in_flight stays 3. FIFO write and pop in the same cycle -> occupancy unchanged.
- rstn pulsed low with in_flight=4, FIFO=2, assembly in HALF -> all outputs 0 immediately. After release: s_ready=1 one cycle later and m_valid=0.
- core_valid_out with in_flight=0 -> err=1 and stays 1; in_flight stays 0; the data word still appears on m_data.
